// File: rtl/dii_ring_router.sv
// dii_ring_router: buffered node on the OSD debug ring.
// Every ring channel and the local port feed an input FIFO. A per-channel
// route machine either forwards a packet downstream or delivers it to the local
// module. Local traffic is merged into one ring channel by a packet-atomic
// round-robin arbiter, and local deliveries are merged the same way.

package dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module dii_ring_router #(
    parameter logic [9:0] ID        = 10'd0,
    parameter int         CHANNELS  = 2,
    parameter int         BUF_DEPTH = 4,
    parameter int         INJECT_CH = 0
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  dii_pkg::dii_flit [CHANNELS-1:0]   ring_in,
    output logic             [CHANNELS-1:0]   ring_in_ready,
    output dii_pkg::dii_flit [CHANNELS-1:0]   ring_out,
    input  logic             [CHANNELS-1:0]   ring_out_ready,
    input  dii_pkg::dii_flit                  local_in,
    output logic                              local_in_ready,
    output dii_pkg::dii_flit                  local_out,
    input  logic                              local_out_ready
);

    // FIFO index CHANNELS is the local-input FIFO; 0..CHANNELS-1 are ring channels.
    localparam int NF = CHANNELS + 1;
    localparam int LF = CHANNELS;
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_LOC  = 2'd2;

    logic [16:0]                mem [NF][BUF_DEPTH];
    logic [NF-1:0][AW:0]        wr_ptr, rd_ptr;
    logic [NF-1:0]              empty, full, push, pop;
    logic [NF-1:0][16:0]        in_word, head;

    logic [CHANNELS-1:0][1:0]   state, route;
    logic [CHANNELS-1:0]        fwd_req, loc_req;

    logic                       inj_lock, inj_owner, inj_ptr;
    logic                       inj_sel, inj_valid, inj_xfer;
    logic                       ring_req, lf_req;
    logic [16:0]                inj_word;

    logic                       lo_lock, lo_found, lo_valid, lo_xfer;
    logic [CW-1:0]              lo_owner, lo_ptr, lo_rr, lo_sel;
    logic [16:0]                lo_word;

    // FIFO status and head words; the extra pointer bit separates full from empty.
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            empty[f] = (wr_ptr[f] == rd_ptr[f]);
            full[f]  = (wr_ptr[f][AW] != rd_ptr[f][AW]) &&
                       (wr_ptr[f][AW-1:0] == rd_ptr[f][AW-1:0]);
            head[f]  = mem[f][rd_ptr[f][AW-1:0]];
        end
    end

    // Input acceptance: readies come only from FIFO fullness and are held low in reset.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ring_in_ready[c] = rstn && !full[c];
            push[c]          = ring_in[c].valid && ring_in_ready[c];
            in_word[c]       = {ring_in[c].last, ring_in[c].data};
        end
        local_in_ready = rstn && !full[LF];
        push[LF]       = local_in.valid && local_in_ready;
        in_word[LF]    = {local_in.last, local_in.data};
    end

    // Effective route per channel: an idle channel decides from its head flit's destination.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (state[c] == ST_IDLE) begin
                route[c] = (head[c][9:0] == ID) ? ST_LOC : ST_FWD;
            end else begin
                route[c] = state[c];
            end
            fwd_req[c] = !empty[c] && (route[c] == ST_FWD);
            loc_req[c] = !empty[c] && (route[c] == ST_LOC);
        end
    end

    // Injection channel arbiter: the locked owner keeps the output, otherwise round-robin.
    always_comb begin
        ring_req = fwd_req[INJECT_CH];
        lf_req   = !empty[LF];
        if (inj_lock) begin
            inj_sel = inj_owner;
        end else if (ring_req && lf_req) begin
            inj_sel = inj_ptr;
        end else begin
            inj_sel = lf_req;
        end
        inj_valid = inj_sel ? lf_req : ring_req;
        inj_word  = inj_sel ? head[LF] : head[INJECT_CH];
        inj_xfer  = inj_valid && ring_out_ready[INJECT_CH];
    end

    // Local delivery arbiter: first LOC requester at or after the pointer, wrapping around.
    always_comb begin
        lo_found = 1'b0;
        lo_rr    = lo_ptr;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!lo_found && loc_req[c] && (CW'(c) >= lo_ptr)) begin
                lo_found = 1'b1;
                lo_rr    = CW'(c);
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (!lo_found && loc_req[c]) begin
                lo_found = 1'b1;
                lo_rr    = CW'(c);
            end
        end
        lo_sel   = lo_lock ? lo_owner : lo_rr;
        lo_valid = 1'b0;
        lo_word  = head[0];
        for (int c = 0; c < CHANNELS; c++) begin
            if (lo_sel == CW'(c)) begin
                lo_valid = loc_req[c];
                lo_word  = head[c];
            end
        end
        lo_xfer = lo_valid && local_out_ready;
    end

    // Output drive and FIFO pops; a pop follows combinationally from the downstream ready.
    always_comb begin
        pop = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (c == INJECT_CH) begin
                ring_out[c].valid = inj_valid;
                ring_out[c].last  = inj_word[16];
                ring_out[c].data  = inj_word[15:0];
                if (!inj_sel && inj_xfer) begin
                    pop[c] = 1'b1;
                end
            end else begin
                ring_out[c].valid = fwd_req[c];
                ring_out[c].last  = head[c][16];
                ring_out[c].data  = head[c][15:0];
                if (fwd_req[c] && ring_out_ready[c]) begin
                    pop[c] = 1'b1;
                end
            end
            if (loc_req[c] && lo_xfer && (lo_sel == CW'(c))) begin
                pop[c] = 1'b1;
            end
        end
        pop[LF]         = inj_sel && inj_xfer;
        local_out.valid = lo_valid;
        local_out.last  = lo_word[16];
        local_out.data  = lo_word[15:0];
    end

    // FIFO storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NF; f++) begin
            if (push[f]) begin
                mem[f][wr_ptr[f][AW-1:0]] <= in_word[f];
            end
        end
    end

    // FIFO pointers; reset empties every FIFO and drops any partial packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int f = 0; f < NF; f++) begin
                if (push[f]) wr_ptr[f] <= wr_ptr[f] + 1'b1;
                if (pop[f])  rd_ptr[f] <= rd_ptr[f] + 1'b1;
            end
        end
    end

    // Route state per channel: hold the packet's route until its last flit leaves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= '{default: ST_IDLE};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (pop[c]) begin
                    state[c] <= head[c][16] ? ST_IDLE : route[c];
                end
            end
        end
    end

    // Injection lock: a presented packet stays granted until its last flit transfers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inj_lock  <= 1'b0;
            inj_owner <= 1'b0;
            inj_ptr   <= 1'b0;
        end else if (inj_valid) begin
            if (inj_xfer && inj_word[16]) begin
                inj_lock <= 1'b0;
                inj_ptr  <= ~inj_sel;
            end else begin
                inj_lock  <= 1'b1;
                inj_owner <= inj_sel;
            end
        end
    end

    // Local delivery lock and pointer, advancing past the channel just served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lo_lock  <= 1'b0;
            lo_owner <= '0;
            lo_ptr   <= '0;
        end else if (lo_valid) begin
            if (lo_xfer && lo_word[16]) begin
                lo_lock <= 1'b0;
                lo_ptr  <= (lo_sel == CW'(CHANNELS - 1)) ? '0 : lo_sel + 1'b1;
            end else begin
                lo_lock  <= 1'b1;
                lo_owner <= lo_sel;
            end
        end
    end

endmodule

// File: doc/dii_ring_router.md
# dii_ring_router

Buffered, parametrised debug-interconnect ring router node for the OSD debug ring. It connects one local debug module (HIM, SCM, DEM, MAM or similar) to `CHANNELS` parallel ring channels. Each ring packet is either delivered to the local module or forwarded, based on its destination ID. Local packets are injected into one selectable channel under packet-atomic round-robin arbitration. Unlike the unbuffered expander, every channel input is registered and FIFO-buffered, so no combinational ready/valid path crosses the node.

## Interface

**Parameters**
- `ID`, default 10'd0: ring address of the local module. Compared against destination bits [9:0] of a packet's first flit.
- `CHANNELS`, default 2: number of parallel ring channels, 1..4.
- `BUF_DEPTH`, default 4: depth of each input FIFO (per channel and local). Power of two, ≥2.
- `INJECT_CH`, default 0: ring channel that carries local_in traffic, 0..CHANNELS-1.

**Ports**
- `clk`, input, 1: single clock. All logic in this one domain.
- `rstn`, input, 1: asynchronous, active-low reset.
- `ring_in`, input, dii_flit[CHANNELS]: upstream ring flits {valid, last, data[15:0]}.
- `ring_in_ready`, output, [CHANNELS]: per-channel accept.
- `ring_out`, output, dii_flit[CHANNELS]: downstream ring flits.
- `ring_out_ready`, input, [CHANNELS]: downstream accept.
- `local_in`, input, dii_flit: packets from the local module.
- `local_in_ready`, output, 1: accept for local_in.
- `local_out`, output, dii_flit: packets delivered to the local module.
- `local_out_ready`, input, 1: local module accept.

## Operation

**Transfers and packets**
- A flit transfers when valid && ready in the same cycle.
- A packet is a run of flits ending with last=1. A single-flit packet has last=1 on its first flit.

**Input FIFOs**
- Each ring channel has a FIFO: IF[c]. The local input has a FIFO: LF.
- IF[c] and LF each hold BUF_DEPTH flits (data and last).
- ring_in_ready[c] = !full(IF[c]). local_in_ready = !full(LF).
- A push and a pop in the same cycle on a full FIFO is not allowed, because ready is low when full.
- A push and a pop in the same cycle on a non-empty, non-full FIFO keeps the occupancy unchanged.

**Per-channel route state machine (one per channel c)**
- States: IDLE, FWD, LOC.
- In IDLE, when IF[c] is non-empty, the head is a first flit. Route decision:
  - head.data[9:0]==ID → LOC.
  - otherwise → FWD.
- data[15:10] are ignored for routing.
- The state machine stays in FWD/LOC until the flit with last=1 is popped, then returns to IDLE.
- A single-flit packet goes IDLE → route → IDLE, with the decision and the pop in the same cycle.

**ring_out[c] for c≠INJECT_CH**
- Driven directly by the IF[c] head when the channel state (or IDLE decision) is FWD.

**ring_out[INJECT_CH] arbiter**
- Sources: the forward stream of IF[INJECT_CH], and LF.
- Two-way round-robin at packet granularity.
- Grant is taken only when no packet is locked. The winner's lock is held until its last flit transfers. The pointer then flips to the other source.
- If only one source is ready, it wins regardless of the pointer.
- After reset the pointer favours the ring (forwarded) source.

**local_out arbiter**
- Sources: all channels whose current packet is routed LOC.
- Round-robin over CHANNELS with the same locking rule.
- After reset the pointer starts at channel 0.

**Other rules**
- A local_in packet whose destination equals ID is still injected into the ring. There is no internal loopback.
- The node never drops, reorders or modifies flits within a channel.

## Timing

- **Reset values** (asynchronous, while rstn=0):
  - All ring_out.valid and local_out.valid = 0.
  - ring_in_ready = 0 and local_in_ready = 0.
  - FIFOs empty; all route state machines in IDLE; locks clear; pointers at reset values.
- **First cycle after rstn deasserts:** ready outputs = 1.
- **Reset mid-packet:** partial packets are discarded, and state is as above. No flit emerges after reset unless it is pushed after reset.
- **Latency:** a flit pushed in cycle t can appear on its output valid in cycle t+1 at the earliest. Output valid depends only on registered state.
- **Combinational paths:**
  - Output ready → input FIFO pop: combinational.
  - ring_out_ready → ring_in_ready: no combinational path.
- **Throughput:** 1 flit/cycle per channel when unblocked.
- **Arbitration handover:** zero bubble. The next packet's first flit can transfer in the cycle after the previous last flit.
- **Back-pressure:** when a LOC-routed head is blocked by local_out, only that channel stalls. Other channels keep forwarding.
- **Valid stability:** once valid is high on any output, valid and data stay stable until ready.

## Test plan

1. **Forward path.** ID=5, CHANNELS=2. A 3-flit packet with dest 7 on ring_in[1], all readys high → the same 3 flits appear on ring_out[1] in cycles t+1..t+3. local_out.valid stays 0.
2. **Local delivery.** A packet with dest 5 (data 0x0005, 0xAAAA, last 0x5555) on ring_in[0] → delivered on local_out, intact. ring_out[0] stays idle.
3. **Injection arbitration.** Continuous 2-flit forward packets on ch0 plus continuous 2-flit local_in packets → ring_out[0] alternates ring/local packet by packet, never interleaving flits, ring packet first after reset.
4. **Back-pressure.** local_out_ready=0 with a LOC packet on ch0 → ring_in_ready[0] drops after BUF_DEPTH=4 accepted flits. Simultaneous ch1 FWD traffic continues at 1 flit/cycle. Release → all flits are delivered in order.
5. **Local_out round-robin.** Single-flit LOC packets arrive on ch0 and ch1 in the same cycle → local_out delivers ch0 then ch1 on consecutive cycles. The next contention is granted ch0 again only after ch1 has been served.
6. **Reset mid-packet.** rstn pulsed low after flit 2 of a 4-flit forwarded packet → outputs go invalid immediately. After release, the FIFOs are empty, and a new packet routes correctly starting from IDLE.
